mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the multicycle core, the unified arbiter and the RAM.
//
// Signal groups:
//   if_*   instruction-fetch requester: req/addr in, ack pulse and last fetched word out
//   dm_*   data requester: req/we/addr/wdata in, ack pulse and last loaded word out
//   mem_*  single-port synchronous RAM: en/we/addr/wdata out, rdata back (LAT cycles later)
//
// Modports:
//   master  the environment around the arbiter (both requesters and the RAM)
//   slave   the arbiter itself
interface mem_arbiter_if #(
  parameter int AW = 10
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic [31:0]   dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Unified memory arbiter for the multicycle MIPS core. One synchronous
// word-addressed RAM is shared between instruction fetch and data access.
// Data wins over fetch, except that after MAX_STREAK consecutive data grants
// made while a fetch was waiting, the fetch is served next.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset; abandons any transaction in flight
//   bus   mem_arbiter_if.slave: both requester handshakes and the RAM port
//   busy  high whenever the arbiter is not in IDLE
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample requests, pick an owner, latch address/we/wdata
// ACCESS | mem_en strobe for one cycle; writes finish here
// WAIT   | read latency countdown; capture mem_rdata when count hits 0
// DONE   | one-cycle ack to the owner
module mem_arbiter #(
  parameter int AW         = 10,
  parameter int LAT        = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic           busy
);

  localparam int CW = 3;
  localparam int SW = 4;
  localparam logic [CW-1:0] WAIT_LOAD  = CW'(LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data port owns the transaction
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          grant_dm, grant_if;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    // Data has priority unless the waiting fetch has been passed over
    // MAX_STREAK times in a row.
    grant_dm = bus.dm_req && !(bus.if_req && (streak_q == STREAK_MAX));
    grant_if = bus.if_req && !grant_dm;

    unique case (state_q)
      IDLE: begin
        if (grant_dm || grant_if) begin
          state_d = ACCESS;
          owner_d = grant_dm;
          we_d    = grant_dm && bus.dm_we;
          addr_d  = grant_dm ? bus.dm_addr : bus.if_addr;
          if (grant_dm) begin
            wdata_d = bus.dm_wdata;
          end
          // The streak only counts data grants that actually kept a fetch waiting.
          if (grant_dm && bus.if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = WAIT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (owner_q) begin
            dm_rdata_d = bus.mem_rdata;
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = (state_q == DONE) && !owner_q;
  assign bus.dm_ack    = (state_q == DONE) && owner_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW         = 10;
  localparam int LAT        = 3;
  localparam int MAX_STREAK = 4;
  localparam int TO         = 100;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_arbiter_if #(.AW(AW)) mbus ();

  mem_arbiter #(.AW(AW), .LAT(LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mbus),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Contents of a RAM word that has never been written.
  function automatic logic [31:0] init_val(input logic [AW-1:0] a);
    return 32'h3C010000 | 32'(a);
  endfunction

  // ---------------- RAM model: LAT-cycle read pipeline, junk when not valid
  logic [31:0]         ram [1<<AW];
  logic [(1<<AW)-1:0]  ram_wr;
  logic [31:0]         pipe_d [LAT];
  logic [LAT-1:0]      pipe_v;
  logic [31:0]         junk;

  always @(posedge clk) begin
    if (rst) begin
      ram_wr <= '0;
    end else if (mbus.mem_en && mbus.mem_we) begin
      ram[mbus.mem_addr]    <= mbus.mem_wdata;
      ram_wr[mbus.mem_addr] <= 1'b1;
    end
    pipe_v[0] <= mbus.mem_en && !mbus.mem_we;
    pipe_d[0] <= ram_wr[mbus.mem_addr] ? ram[mbus.mem_addr] : init_val(mbus.mem_addr);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    junk <= $urandom;
  end

  assign mbus.mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

  // ---------------- Requests issued, waiting for their ack (scoreboard input)
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  req_t if_q[$];
  req_t dm_q[$];
  bit   ack_log[$];   // ack order seen on the DUT: 1 = data, 0 = fetch

  task automatic issue_if(input logic [AW-1:0] a);
    mbus.if_req  = 1'b1;
    mbus.if_addr = a;
    if_q.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic issue_dm(input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    mbus.dm_req   = 1'b1;
    mbus.dm_we    = we;
    mbus.dm_addr  = a;
    mbus.dm_wdata = d;
    dm_q.push_back('{we, a, d});
  endtask

  task automatic wait_ack(input bit dm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < TO && !got; n++) begin
      @(negedge clk);
      got = dm ? mbus.dm_ack : mbus.if_ack;
    end
    chk(dm ? "dm_ack_wait" : "if_ack_wait", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_agent(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        mbus.if_req = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      issue_if(AW'($urandom_range(0, 15)));
      wait_ack(1'b0);
    end
    mbus.if_req = 1'b0;
  endtask

  task automatic data_agent(input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        mbus.dm_req = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      issue_dm(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      wait_ack(1'b1);
    end
    mbus.dm_req = 1'b0;
  endtask

  // ---------------- Reference model + monitor
  logic [31:0] ref_mem [int];
  bit          prev_if, prev_dm, prev_busy, in_txn, in_port, in_we;
  int          in_ack_cyc, streak;
  logic [31:0] in_rdata, exp_if_rd, exp_dm_rd;

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  always @(negedge clk) begin
    bit   exp_en, own_dm, exp_ifa, exp_dma, exp_busy;
    req_t r;
    if (rst) begin
      prev_if = 0; prev_dm = 0; prev_busy = 0; in_txn = 0; streak = 0;
      exp_if_rd = '0; exp_dm_rd = '0;
      if_q.delete(); dm_q.delete(); ref_mem.delete();
    end else begin
      // A pending request seen in an idle cycle is granted and strobed next cycle.
      exp_en = !prev_busy && (prev_if || prev_dm);
      chk("mem_en", 32'(mbus.mem_en), 32'(exp_en));
      if (exp_en) begin
        own_dm = prev_dm && !(prev_if && streak == MAX_STREAK);
        if (own_dm && prev_if) streak = (streak < MAX_STREAK) ? streak + 1 : streak;
        else streak = 0;
        r = own_dm ? dm_q[0] : if_q[0];
        chk("mem_we", 32'(mbus.mem_we), 32'(r.we));
        chk("mem_addr", 32'(mbus.mem_addr), 32'(r.addr));
        if (r.we) begin
          chk("mem_wdata", mbus.mem_wdata, r.wdata);
          ref_mem[int'(r.addr)] = r.wdata;
        end else begin
          in_rdata = ref_rd(r.addr);
        end
        in_txn     = 1;
        in_port    = own_dm;
        in_we      = r.we;
        in_ack_cyc = cyc + (r.we ? 1 : LAT + 1);
      end else begin
        chk("mem_we_idle", 32'(mbus.mem_we), 32'd0);
      end
      exp_ifa = in_txn && !in_port && (cyc == in_ack_cyc);
      exp_dma = in_txn && in_port && (cyc == in_ack_cyc);
      chk("if_ack", 32'(mbus.if_ack), 32'(exp_ifa));
      chk("dm_ack", 32'(mbus.dm_ack), 32'(exp_dma));
      if (mbus.if_ack) ack_log.push_back(1'b0);
      if (mbus.dm_ack) ack_log.push_back(1'b1);
      if (exp_ifa) begin
        exp_if_rd = in_rdata;
        void'(if_q.pop_front());
      end
      if (exp_dma) begin
        if (!in_we) exp_dm_rd = in_rdata;
        void'(dm_q.pop_front());
      end
      chk("if_rdata", mbus.if_rdata, exp_if_rd);
      chk("dm_rdata", mbus.dm_rdata, exp_dm_rd);
      exp_busy = exp_en || in_txn;
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_ifa || exp_dma) in_txn = 0;
      prev_busy = exp_busy;
      prev_if   = mbus.if_req;
      prev_dm   = mbus.dm_req;
    end
  end

  // ---------------- Directed helpers
  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},      32'(busy),          32'd0);
    chk({nm, "_mem_en"},    32'(mbus.mem_en),   32'd0);
    chk({nm, "_mem_we"},    32'(mbus.mem_we),   32'd0);
    chk({nm, "_mem_addr"},  32'(mbus.mem_addr), 32'd0);
    chk({nm, "_mem_wdata"}, mbus.mem_wdata,     32'd0);
    chk({nm, "_if_ack"},    32'(mbus.if_ack),   32'd0);
    chk({nm, "_dm_ack"},    32'(mbus.dm_ack),   32'd0);
    chk({nm, "_if_rdata"},  mbus.if_rdata,      32'd0);
    chk({nm, "_dm_rdata"},  mbus.dm_rdata,      32'd0);
  endtask

  task automatic chk_log(input string nm, input logic [31:0] exp, input int n);
    logic [31:0] act;
    act = '0;
    foreach (ack_log[i]) act = {act[30:0], ack_log[i]};
    chk({nm, "_count"}, 32'(ack_log.size()), 32'(n));
    chk(nm, act, exp);
  endtask

  initial begin
    rst = 1'b1;
    mbus.if_req = 1'b0; mbus.if_addr = '0;
    mbus.dm_req = 1'b0; mbus.dm_we = 1'b0; mbus.dm_addr = '0; mbus.dm_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;

    // Single fetch from a preloaded word.
    issue_if(AW'(1));
    wait_ack(1'b0);
    mbus.if_req = 1'b0;
    chk("t1_if_rdata", mbus.if_rdata, 32'h3C010001);

    // Single store; load data register must stay untouched.
    issue_dm(1'b1, AW'(4), 32'hDEADBEEF);
    wait_ack(1'b1);
    mbus.dm_req = 1'b0;
    chk("t2_dm_rdata", mbus.dm_rdata, 32'd0);

    // Simultaneous fetch and load: data first, then fetch.
    ack_log.delete();
    issue_if(AW'(2));
    issue_dm(1'b0, AW'(4), 32'd0);
    fork
      begin wait_ack(1'b1); mbus.dm_req = 1'b0; end
      begin wait_ack(1'b0); mbus.if_req = 1'b0; end
    join
    chk_log("t3_order", 32'b10, 2);
    chk("t3_dm_rdata", mbus.dm_rdata, 32'hDEADBEEF);
    chk("t3_if_rdata", mbus.if_rdata, 32'h3C010002);

    // Streak guard: back-to-back data with a fetch held pending.
    ack_log.delete();
    issue_if(AW'(3));
    fork
      begin wait_ack(1'b0); mbus.if_req = 1'b0; end
      begin
        for (int i = 0; i < 5; i++) begin
          issue_dm(1'b1, AW'(16 + i), $urandom);
          wait_ack(1'b1);
        end
        mbus.dm_req = 1'b0;
      end
    join
    chk_log("t4_order", 32'b111101, 6);

    // Reset while a read sits in its latency wait.
    issue_if(AW'(5));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mbus.if_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("t5_after_rst");
    repeat (2) @(posedge clk);
    #1;
    issue_if(AW'(6));
    wait_ack(1'b0);
    mbus.if_req = 1'b0;
    chk("t5_if_rdata", mbus.if_rdata, 32'h3C010006);

    // Fetch of a stored word, with a second fetch held high straight after.
    issue_dm(1'b1, AW'(7), 32'h12345678);
    wait_ack(1'b1);
    mbus.dm_req = 1'b0;
    issue_if(AW'(7));
    wait_ack(1'b0);
    issue_if(AW'(8));
    chk("t6_if_rdata_hold", mbus.if_rdata, 32'h12345678);
    wait_ack(1'b0);
    mbus.if_req = 1'b0;
    chk("t6_if_rdata_next", mbus.if_rdata, 32'h3C010008);

    // Randomized concurrent traffic.
    fork
      fetch_agent(40);
      data_agent(60);
    join

    repeat (5) @(posedge clk);
    #1;
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
